// File: rtl/adc_scan_sequencer.sv
// Channel-scanning master for the AD79X8 serial engine: power-up dummy conversions,
// per-channel control words, tagged results with a one-cycle valid strobe.
module adc_scan_sequencer #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        single_i,
    input  logic [7:0]  channel_mask_i,
    input  logic        range_sel_i,
    input  logic        coding_i,
    input  logic        engine_cs_i,
    input  logic [15:0] engine_data_i,
    output logic [15:0] engine_ctrl_o,
    output logic        engine_start_o,
    output logic        result_valid_o,
    output logic [2:0]  result_channel_o,
    output logic [11:0] result_data_o,
    output logic        scan_done_o,
    output logic        busy_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_START, S_XFER, S_CAPTURE, S_GAP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        dummy_q, dummy_d;
    logic        dummy_cnt_q, dummy_cnt_d;
    logic        first_q, first_d;
    logic        flush_q, flush_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic        range_q, range_d;
    logic        coding_q, coding_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic        start_q, start_d;
    logic        valid_q, valid_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic [11:0] res_data_q, res_data_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        scan_begin;
    logic [7:0]  scan_src;
    logic [2:0]  next_ch;
    logic        rng, cod;
    logic        gap_last;
    logic        unused_msb;

    // A new scan samples mask and config straight from the inputs; mid-scan uses the latched copy.
    assign scan_begin = (state_q == S_IDLE) || (state_q == S_DONE);
    assign scan_src   = scan_begin ? channel_mask_i : mask_q;
    assign rng        = scan_begin ? range_sel_i : range_q;
    assign cod        = scan_begin ? coding_i : coding_q;
    assign gap_last   = (gap_cnt_q == GW'(GAP_LAST));
    assign unused_msb = engine_data_i[15];

    always_comb begin
        next_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (scan_src[i]) next_ch = 3'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_WAIT_IDLE;
            dummy_q     <= 1'b0;
            dummy_cnt_q <= 1'b0;
            first_q     <= 1'b0;
            flush_q     <= 1'b0;
            mask_q      <= '0;
            cur_ch_q    <= '0;
            prev_ch_q   <= '0;
            range_q     <= 1'b0;
            coding_q    <= 1'b0;
            gap_cnt_q   <= '0;
            ctrl_q      <= 16'h0000;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dummy_q     <= dummy_d;
            dummy_cnt_q <= dummy_cnt_d;
            first_q     <= first_d;
            flush_q     <= flush_d;
            mask_q      <= mask_d;
            cur_ch_q    <= cur_ch_d;
            prev_ch_q   <= prev_ch_d;
            range_q     <= range_d;
            coding_q    <= coding_d;
            gap_cnt_q   <= gap_cnt_d;
            ctrl_q      <= ctrl_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_IDLE: if (engine_cs_i) state_d = S_START;
            S_IDLE:      if ((enable_i || single_i) && channel_mask_i != 8'h00) state_d = S_START;
            S_START:     if (!engine_cs_i) state_d = S_XFER;
            S_XFER:      if (engine_cs_i) state_d = S_CAPTURE;
            S_CAPTURE:   state_d = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    if (dummy_q)      state_d = dummy_cnt_q ? S_IDLE : S_START;
                    else if (flush_q) state_d = S_DONE;
                    else              state_d = S_START;
                end
            end
            S_DONE:      state_d = (enable_i && channel_mask_i != 8'h00) ? S_START : S_IDLE;
            default:     state_d = S_WAIT_IDLE;
        endcase
    end

    always_comb begin
        dummy_d     = dummy_q;
        dummy_cnt_d = dummy_cnt_q;
        first_d     = first_q;
        flush_d     = flush_q;
        mask_d      = mask_q;
        cur_ch_d    = cur_ch_q;
        prev_ch_d   = prev_ch_q;
        range_d     = range_q;
        coding_d    = coding_q;
        gap_cnt_d   = (state_q == S_GAP) ? gap_cnt_q + GW'(1) : '0;
        ctrl_d      = ctrl_q;
        start_d     = start_q;
        valid_d     = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;
        err_d       = err_q;

        if (state_d == S_START && state_q != S_START) begin
            start_d = 1'b1;
            if (state_q == S_WAIT_IDLE) begin
                dummy_d     = 1'b1;
                dummy_cnt_d = 1'b0;
                ctrl_d      = 16'hFFFF;
            end else if (dummy_q) begin
                dummy_cnt_d = 1'b1;
                ctrl_d      = 16'hFFFF;
            end else begin
                if (scan_begin) begin
                    busy_d   = 1'b1;
                    first_d  = 1'b1;
                    range_d  = range_sel_i;
                    coding_d = coding_i;
                end
                prev_ch_d = cur_ch_q;
                if (scan_src != 8'h00) begin
                    ctrl_d   = {1'b1, 2'b00, next_ch, 2'b11, 2'b00, rng, cod, 4'b0000};
                    mask_d   = scan_src & ~(8'd1 << next_ch);
                    cur_ch_d = next_ch;
                    flush_d  = 1'b0;
                end else begin
                    ctrl_d   = 16'h0000;
                    mask_d   = 8'h00;
                    flush_d  = 1'b1;
                end
            end
        end

        if (state_q == S_START && !engine_cs_i) start_d = 1'b0;

        // Each result belongs to the channel addressed one transaction earlier.
        if (state_q == S_XFER && engine_cs_i && !dummy_q) begin
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                valid_d    = 1'b1;
                res_ch_d   = engine_data_i[14:12];
                res_data_d = engine_data_i[11:0];
                if (engine_data_i[14:12] != prev_ch_q) err_d = 1'b1;
            end
        end

        if (state_q == S_GAP && state_d == S_IDLE) begin
            ready_d = 1'b1;
            dummy_d = 1'b0;
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign engine_ctrl_o    = ctrl_q;
    assign engine_start_o   = start_q;
    assign result_valid_o   = valid_q;
    assign result_channel_o = res_ch_q;
    assign result_data_o    = res_data_q;
    assign scan_done_o      = done_q;
    assign busy_o           = busy_q;
    assign ready_o          = ready_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural AD79X8 engine that echoes
// the previously written channel address as the result tag.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        single;
    logic [7:0]  channelMask;
    logic        rangeSel;
    logic        coding;
    logic        engineCs = 1'b1;
    logic [15:0] engineData = 16'h0000;
    logic [15:0] engineCtrl;
    logic        engineStart;
    logic        resultValid;
    logic [2:0]  resultChannel;
    logic [11:0] resultData;
    logic        scanDone;
    logic        busy;
    logic        ready;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Engine model state; it has no reset, just like the real engine.
    int          engCnt = 0;
    logic [15:0] engLatched = 16'h0000;
    logic [2:0]  engAddr = 3'd0;
    logic        corrupt = 1'b0;

    logic [15:0] ctrlLog[$];
    logic [2:0]  chanLog[$];
    logic [11:0] dataLog[$];
    int          gapLog[$];
    int          doneCount = 0;
    int          startCount = 0;
    int          busyCount = 0;
    int          csHighRun = 0;
    logic        sawLow = 1'b0;

    always #5 clk = ~clk;

    adc_scan_sequencer #(.GAP_CYCLES(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .single_i(single),
        .channel_mask_i(channelMask),
        .range_sel_i(rangeSel),
        .coding_i(coding),
        .engine_cs_i(engineCs),
        .engine_data_i(engineData),
        .engine_ctrl_o(engineCtrl),
        .engine_start_o(engineStart),
        .result_valid_o(resultValid),
        .result_channel_o(resultChannel),
        .result_data_o(resultData),
        .scan_done_o(scanDone),
        .busy_o(busy),
        .ready_o(ready),
        .err_o(err)
    );

    // 16-cycle transaction; the returned word carries the address written previously.
    always @(posedge clk) begin
        if (engCnt == 0) begin
            if (engineStart) begin
                engineCs   <= 1'b0;
                engCnt     <= 16;
                engLatched <= engineCtrl;
                ctrlLog.push_back(engineCtrl);
            end
        end else begin
            engCnt <= engCnt - 1;
            if (engCnt == 1) begin
                engineCs   <= 1'b1;
                engineData <= {1'b0, (corrupt && engAddr == 3'd2) ? 3'd3 : engAddr,
                               12'h5A0 + {9'd0, engAddr}};
                if (engLatched[15]) engAddr <= engLatched[12:10];
            end
        end
    end

    always @(negedge clk) begin
        if (resultValid) begin
            chanLog.push_back(resultChannel);
            dataLog.push_back(resultData);
        end
        if (scanDone) doneCount++;
        if (engineStart) startCount++;
        if (busy) busyCount++;
        if (engineCs) begin
            csHighRun++;
        end else begin
            if (sawLow && csHighRun > 0) gapLog.push_back(csHighRun);
            csHighRun = 0;
            sawLow = 1'b1;
        end
    end

    function automatic logic [15:0] ctrlAt(int i);
        return (i < ctrlLog.size()) ? ctrlLog[i] : 16'hxxxx;
    endfunction

    function automatic logic [2:0] chanAt(int i);
        return (i < chanLog.size()) ? chanLog[i] : 3'bxxx;
    endfunction

    function automatic logic [11:0] dataAt(int i);
        return (i < dataLog.size()) ? dataLog[i] : 12'hxxx;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int ctrlBase;
        int resBase;
        int cycles;
        repeat (3) tick();
        vectors++;
        if ({engineCtrl, engineStart, resultValid, resultChannel, resultData, scanDone, busy, ready, err} !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ctrl=%h start=%b busy=%b ready=%b err=%b, expected all zero",
                     engineCtrl, engineStart, busy, ready, err);
        end
        ctrlBase = ctrlLog.size();
        resBase  = chanLog.size();
        rst = 1'b0;
        cycles = 0;
        while (!ready && cycles < 300) begin
            tick();
            cycles++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b, expected 1 within 300 cycles", ready);
        end
        vectors++;
        if (ctrlLog.size() - ctrlBase != 2) begin
            miscompares++;
            $display("[TB] FAIL reset_dummy_count: got %0d transactions, expected 2", ctrlLog.size() - ctrlBase);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (ctrlAt(ctrlBase + i) !== 16'hFFFF) begin
                miscompares++;
                $display("[TB] FAIL reset_dummy_word%0d: got %h, expected FFFF", i, ctrlAt(ctrlBase + i));
            end
        end
        vectors++;
        if (chanLog.size() != resBase || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_result: got %0d results err=%b, expected 0 results err=0",
                     chanLog.size() - resBase, err);
        end
    endtask

    task automatic runSingle(input logic [7:0] mask, input logic rs, input logic cd, output logic busyAfterStart, output int doneSeen);
        int doneBase;
        int cycles;
        doneBase    = doneCount;
        channelMask = mask;
        rangeSel    = rs;
        coding      = cd;
        single      = 1'b1;
        tick();
        single      = 1'b0;
        busyAfterStart = busy;
        cycles = 0;
        while (doneCount == doneBase && cycles < 400) begin
            tick();
            cycles++;
        end
        repeat (10) tick();
        doneSeen = doneCount - doneBase;
    endtask

    task automatic test_single();
        int ctrlBase;
        int resBase;
        int doneSeen;
        logic busyAfterStart;
        ctrlBase = ctrlLog.size();
        resBase  = chanLog.size();
        runSingle(8'h05, 1'b0, 1'b1, busyAfterStart, doneSeen);
        vectors++;
        if (busyAfterStart !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_busy: got %b, expected 1 after start", busyAfterStart);
        end
        vectors++;
        if (ctrlLog.size() - ctrlBase != 3) begin
            miscompares++;
            $display("[TB] FAIL single_txn_count: got %0d, expected 3", ctrlLog.size() - ctrlBase);
        end
        vectors++;
        if ({ctrlAt(ctrlBase), ctrlAt(ctrlBase + 1), ctrlAt(ctrlBase + 2)} !== {16'h8310, 16'h8B10, 16'h0000}) begin
            miscompares++;
            $display("[TB] FAIL single_ctrl_seq: got %h %h %h, expected 8310 8B10 0000",
                     ctrlAt(ctrlBase), ctrlAt(ctrlBase + 1), ctrlAt(ctrlBase + 2));
        end
        vectors++;
        if (chanLog.size() - resBase != 2 || chanAt(resBase) !== 3'd0 || chanAt(resBase + 1) !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL single_results: got %0d results ch %0d,%0d, expected 2 results ch 0,2",
                     chanLog.size() - resBase, chanAt(resBase), chanAt(resBase + 1));
        end
        vectors++;
        if (dataAt(resBase) !== 12'h5A0 || dataAt(resBase + 1) !== 12'h5A2) begin
            miscompares++;
            $display("[TB] FAIL single_data: got %h %h, expected 5A0 5A2", dataAt(resBase), dataAt(resBase + 1));
        end
        vectors++;
        if (doneSeen != 1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_done: got done=%0d busy=%b err=%b, expected 1 0 0", doneSeen, busy, err);
        end
    endtask

    task automatic test_mismatch();
        int resBase;
        int doneSeen;
        logic busyAfterStart;
        corrupt = 1'b1;
        resBase = chanLog.size();
        runSingle(8'h05, 1'b0, 1'b1, busyAfterStart, doneSeen);
        vectors++;
        if (chanLog.size() - resBase != 2 || chanAt(resBase) !== 3'd0 || chanAt(resBase + 1) !== 3'd3) begin
            miscompares++;
            $display("[TB] FAIL mismatch_tag: got %0d results ch %0d,%0d, expected 2 results ch 0,3",
                     chanLog.size() - resBase, chanAt(resBase), chanAt(resBase + 1));
        end
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mismatch_err: got %b, expected 1", err);
        end
        corrupt = 1'b0;
        resBase = chanLog.size();
        runSingle(8'h05, 1'b0, 1'b1, busyAfterStart, doneSeen);
        vectors++;
        if (err !== 1'b1 || chanAt(resBase) !== 3'd0 || chanAt(resBase + 1) !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL mismatch_sticky: got err=%b ch %0d,%0d, expected err=1 ch 0,2",
                     err, chanAt(resBase), chanAt(resBase + 1));
        end
    endtask

    task automatic test_zero_mask();
        int startBase;
        int busyBase;
        int ctrlBase;
        startBase   = startCount;
        busyBase    = busyCount;
        ctrlBase    = ctrlLog.size();
        channelMask = 8'h00;
        enable      = 1'b1;
        repeat (100) tick();
        vectors++;
        if (startCount != startBase || ctrlLog.size() != ctrlBase) begin
            miscompares++;
            $display("[TB] FAIL zero_mask_start: got %0d start cycles, expected 0", startCount - startBase);
        end
        vectors++;
        if (busyCount != busyBase) begin
            miscompares++;
            $display("[TB] FAIL zero_mask_busy: got %0d busy cycles, expected 0", busyCount - busyBase);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_full_mask();
        int ctrlBase;
        int resBase;
        int doneBase;
        int gapBase;
        int cycles;
        int gapMin;
        logic [15:0] expWord;
        ctrlBase    = ctrlLog.size();
        resBase     = chanLog.size();
        doneBase    = doneCount;
        gapBase     = gapLog.size();
        channelMask = 8'hFF;
        rangeSel    = 1'b1;
        coding      = 1'b0;
        enable      = 1'b1;
        cycles = 0;
        while (doneCount - doneBase < 1 && cycles < 600) begin
            tick();
            cycles++;
        end
        repeat (5) tick();
        enable = 1'b0;
        cycles = 0;
        while (doneCount - doneBase < 2 && cycles < 600) begin
            tick();
            cycles++;
        end
        repeat (20) tick();
        vectors++;
        if (doneCount - doneBase != 2 || ctrlLog.size() - ctrlBase != 18) begin
            miscompares++;
            $display("[TB] FAIL full_counts: got done=%0d txns=%0d, expected done=2 txns=18",
                     doneCount - doneBase, ctrlLog.size() - ctrlBase);
        end
        for (int i = 0; i < 18; i++) begin
            expWord = ((i % 9) == 8) ? 16'h0000 : (16'h8320 | (16'(i % 9) << 10));
            vectors++;
            if (ctrlAt(ctrlBase + i) !== expWord) begin
                miscompares++;
                $display("[TB] FAIL full_ctrl%0d: got %h, expected %h", i, ctrlAt(ctrlBase + i), expWord);
            end
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (chanAt(resBase + i) !== 3'(i % 8) || dataAt(resBase + i) !== 12'h5A0 + 12'(i % 8)) begin
                miscompares++;
                $display("[TB] FAIL full_result%0d: got ch %0d data %h, expected ch %0d data %h",
                         i, chanAt(resBase + i), dataAt(resBase + i), i % 8, 12'h5A0 + 12'(i % 8));
            end
        end
        gapMin = 1000;
        for (int i = gapBase; i < gapLog.size(); i++) begin
            if (gapLog[i] < gapMin) gapMin = gapLog[i];
        end
        vectors++;
        if (gapMin < 3 || gapMin == 1000) begin
            miscompares++;
            $display("[TB] FAIL full_gap: got min cs-high run %0d, expected >= 3", gapMin);
        end
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_end_state: got err=%b busy=%b, expected err=1 busy=0", err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int ctrlBase;
        int resBase;
        int startBase;
        int cycles;
        channelMask = 8'h01;
        single      = 1'b1;
        tick();
        single      = 1'b0;
        cycles = 0;
        while (engineCs && cycles < 50) begin
            tick();
            cycles++;
        end
        repeat (5) tick();
        vectors++;
        if (engineCs !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_setup: got cs=%b busy=%b, expected cs=0 busy=1", engineCs, busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({engineCtrl, engineStart, resultValid, resultChannel, resultData, scanDone, busy, ready, err} !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_async_reset: got ctrl=%h busy=%b ready=%b err=%b, expected all zero",
                     engineCtrl, busy, ready, err);
        end
        repeat (2) tick();
        ctrlBase  = ctrlLog.size();
        resBase   = chanLog.size();
        startBase = startCount;
        rst = 1'b0;
        cycles = 0;
        while (!engineCs && cycles < 40) begin
            tick();
            cycles++;
        end
        vectors++;
        if (engineCs !== 1'b1 || startCount != startBase) begin
            miscompares++;
            $display("[TB] FAIL mid_wait_idle: got cs=%b start cycles=%0d, expected cs=1 start cycles=0",
                     engineCs, startCount - startBase);
        end
        cycles = 0;
        while (!ready && cycles < 300) begin
            tick();
            cycles++;
        end
        vectors++;
        if (ready !== 1'b1 || ctrlLog.size() - ctrlBase != 2 ||
            ctrlAt(ctrlBase) !== 16'hFFFF || ctrlAt(ctrlBase + 1) !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL mid_dummy: got ready=%b txns=%0d words %h %h, expected ready=1 txns=2 FFFF FFFF",
                     ready, ctrlLog.size() - ctrlBase, ctrlAt(ctrlBase), ctrlAt(ctrlBase + 1));
        end
        vectors++;
        if (err !== 1'b0 || chanLog.size() != resBase) begin
            miscompares++;
            $display("[TB] FAIL mid_clean: got err=%b results=%0d, expected err=0 results=0",
                     err, chanLog.size() - resBase);
        end
    endtask

    // Scenarios run back to back; each leaves the DUT idle for the next one.
    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        single      = 1'b0;
        channelMask = 8'h00;
        rangeSel    = 1'b0;
        coding      = 1'b0;
        test_reset();
        test_single();
        test_mismatch();
        test_zero_mask();
        test_full_mask();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
